audio_out_scheduler: RTL and testbench
======================================

// Module: audio_out_scheduler
// PURPOSE
//  Sits between the MCU parallel sample bus and the Audio_Controller DAC path on the DE1.
//  Synchronises the MCU write strobe and buffers samples in a small FIFO.
//  Issues single-cycle write_audio_out pulses only while the codec reports audio_out_allowed.
//  Provides MCU flow control (sample_ready) plus overflow and underrun status for debug.
// PARAMETERS
//  DATA_WIDTH      16    sample width; the same sample drives both channels (mono)
//  FIFO_DEPTH      8     sample FIFO entries; must be a power of 2 and >= 4
//  SYNC_STAGES     2     flip-flop stages on sample_wr
//  READY_MARGIN    2     sample_ready = (fifo_level < FIFO_DEPTH-READY_MARGIN)
//  UNDERRUN_CYCLES 1024  consecutive starved cycles before underrun is set
// PORTS
//  CLOCK_50                 in   1      system clock; the only clock
//  reset                    in   1      synchronous, active-high
//  enable                   in   1      0 = flush FIFO, clear status, no writes
//  sample_in                in   DW     MCU sample; stable from sample_wr rise for >= SYNC_STAGES+2 clocks
//  sample_wr                in   1      MCU write strobe, asynchronous; a rising edge pushes one sample
//  sample_ready             out  1      MCU may write
//  audio_out_allowed        in   1      from Audio_Controller; its output FIFO has space
//  write_audio_out          out  1      to Audio_Controller; one-cycle write pulse
//  left_channel_audio_out   out  DW     sample presented with the write pulse
//  right_channel_audio_out  out  DW     same value as the left channel
//  overflow_count           out  8      dropped pushes; saturates at 255
//  underrun                 out  1      sticky starvation flag
//  fifo_level               out  $clog2(FIFO_DEPTH)+1  current occupancy
// BEHAVIOUR
//  Reset: all outputs, FIFO pointers, sync flops, counters and FSM go to 0/IDLE.
//  Input: sample_wr passes through SYNC_STAGES flops; a 0->1 on the synchronised signal is a push.
//   sample_in is captured on that same edge.
//  Push when not full: write the entry; fifo_level increments on the next cycle.
//  Push when full: drop the sample; overflow_count++ (saturating). Full is evaluated before any same-cycle pop.
//  Same-cycle push and pop: both happen and fifo_level is unchanged.
//  sample_ready is registered and equals enable && (level < FIFO_DEPTH-READY_MARGIN).
//  FSM states: IDLE, ISSUE, GAP.
//   IDLE -> ISSUE when enable && !empty && audio_out_allowed. At that edge:
//    pop the head, load it into both channel outputs, set write_audio_out=1.
//   ISSUE -> GAP unconditionally; write_audio_out=0. ISSUE lasts exactly 1 cycle.
//   GAP -> IDLE unconditionally. GAP lets audio_out_allowed update.
//   Maximum rate is 1 write per 3 clocks.
//  Latency: sample_wr rise to write_audio_out high is <= SYNC_STAGES+4 clocks when FIFO is empty and allowed=1.
//  Channel outputs hold the last written sample between pulses; they are never modified outside ISSUE entry.
//  Underrun: once >= 1 sample has been written since enable rose, count consecutive cycles
//   with empty && audio_out_allowed. At UNDERRUN_CYCLES, set underrun; it stays set until enable=0 or reset.
//   Any non-empty cycle clears the counter.
//  enable=0, sampled synchronously, takes effect on the next edge:
//   flush the FIFO (level=0), FSM -> IDLE, write_audio_out=0.
//   Clear overflow_count, underrun and the starve counter; pushes are ignored.
//   A pulse already in ISSUE completes as its normal single cycle. Channel outputs hold their value.
//  Reset mid-operation overrides everything, including an in-flight pulse (write_audio_out=0 next cycle).
//  Arithmetic: pointers wrap modulo FIFO_DEPTH; level uses an extra bit to separate full from empty; no sample scaling.
// STRUCTURE
//  audio_pkg holds AUDIO_DATA_WIDTH=16 and typedef enum logic[1:0] {IDLE, ISSUE, GAP} aos_state_t.
//  Sub-module sample_fifo: synchronous FIFO with push/pop/flush, level, full and empty; head is visible combinationally.
//  Strobe sync/edge-detect, FSM, underrun timer and overflow counter are inline.
// TESTING
//  1 Reset with sample_wr=1 -> write=0, ready=0, level=0, channels=0, counts=0; no push after reset releases.
//  2 enable=1, allowed=1, strobe 16'h1234 -> one write pulse <= SYNC_STAGES+4 clocks later; L=R=16'h1234.
//  3 allowed=0, strobe 0x0001..0x0009 -> ready falls after the 6th push; level=8, overflow_count=1.
//    Then allowed=1 -> 8 pulses carrying 0x0001..0x0008 in order, 3 clocks apart.
//  4 UNDERRUN_CYCLES=16: play one sample and hold allowed=1 -> underrun=1 on the 16th starved cycle;
//    it persists until enable=0.
//  5 With level=5, drop enable for 1 clock -> level=0 next cycle, no further pulses, counts cleared, channels unchanged.
//  6 At level=3, a push coincides with IDLE->ISSUE -> level stays 3 and FIFO order is preserved.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio output scheduler.
//   AUDIO_DATA_WIDTH : default sample width for the DAC path
//   aos_state_t      : write-issue FSM states
package audio_pkg;

  localparam int unsigned AUDIO_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } aos_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with flush.
//   clk, reset     : clock, synchronous active-high reset
//   flush          : empties the FIFO on the next edge
//   push, din      : write request and data (ignored when full)
//   pop            : read request (ignored when empty)
//   head           : oldest entry, visible combinationally
//   level          : occupancy, one bit wider than the pointer index
//   full, empty    : occupancy flags
module sample_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Extra pointer bit separates full from empty; subtraction wraps naturally.
  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == (AW + 1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/audio_out_scheduler.sv
// Buffers MCU samples and paces single-cycle writes into the Audio_Controller DAC path.
//   CLOCK_50, reset          : only clock, synchronous active-high reset
//   enable                   : 0 flushes the FIFO and clears status
//   sample_in, sample_wr     : MCU sample and asynchronous write strobe (rising edge pushes)
//   sample_ready             : MCU may write
//   audio_out_allowed        : codec output FIFO has space
//   write_audio_out          : one-cycle write pulse
//   left/right_channel_audio_out : sample presented with the pulse (mono, both equal)
//   overflow_count           : saturating count of dropped pushes
//   underrun                 : sticky starvation flag
//   fifo_level               : current FIFO occupancy
module audio_out_scheduler
  import audio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = AUDIO_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned READY_MARGIN    = 2,
  parameter int unsigned UNDERRUN_CYCLES = 1024
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [DATA_WIDTH-1:0]         sample_in,
  input  logic                          sample_wr,
  output logic                          sample_ready,
  input  logic                          audio_out_allowed,
  output logic                          write_audio_out,
  output logic [DATA_WIDTH-1:0]         left_channel_audio_out,
  output logic [DATA_WIDTH-1:0]         right_channel_audio_out,
  output logic [7:0]                    overflow_count,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SW = $clog2(UNDERRUN_CYCLES + 1);

  aos_state_t            state_q, state_d;
  logic [SYNC_STAGES:0]  sync_q;   // top bit is the edge-detect delay stage
  logic [SYNC_STAGES:0]  vld_q;    // marks stages holding post-reset data
  logic                  armed_q;
  logic                  wr_sync, wr_prev, push_evt, pop;
  logic [DATA_WIDTH-1:0] chan_q, head;
  logic                  ready_q, played_q, underrun_q;
  logic [7:0]            ovf_q;
  logic [SW-1:0]         starve_q;
  logic                  full, empty;
  logic [LW-1:0]         level;

  assign wr_sync = sync_q[SYNC_STAGES-1];
  assign wr_prev = sync_q[SYNC_STAGES];
  // Only arm after a genuine low has been seen, so a strobe held high through
  // reset is not mistaken for a new edge.
  assign push_evt = enable & armed_q & wr_sync & ~wr_prev;

  sample_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLOCK_50),
    .reset (reset),
    .flush (~enable),
    .push  (push_evt),
    .pop   (pop),
    .din   (sample_in),
    .head  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && !empty && audio_out_allowed) begin
          state_d = ISSUE;
          pop     = 1'b1;
        end
      end
      ISSUE:   state_d = enable ? GAP : IDLE;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      vld_q      <= '0;
      armed_q    <= 1'b0;
      chan_q     <= '0;
      ready_q    <= 1'b0;
      played_q   <= 1'b0;
      underrun_q <= 1'b0;
      ovf_q      <= '0;
      starve_q   <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[SYNC_STAGES-1:0], sample_wr};
      vld_q   <= {vld_q[SYNC_STAGES-1:0], 1'b1};
      if (vld_q[SYNC_STAGES-1] && !wr_sync) armed_q <= 1'b1;
      if (pop) chan_q <= head;
      ready_q <= enable && (level < LW'(FIFO_DEPTH - READY_MARGIN));
      if (!enable) begin
        ovf_q      <= '0;
        underrun_q <= 1'b0;
        starve_q   <= '0;
        played_q   <= 1'b0;
      end else begin
        if (push_evt && full && (ovf_q != 8'hFF)) ovf_q <= ovf_q + 8'd1;
        if (pop) played_q <= 1'b1;
        if (!empty) begin
          starve_q <= '0;
        end else if (played_q && audio_out_allowed) begin
          if (starve_q < SW'(UNDERRUN_CYCLES)) starve_q <= starve_q + 1'b1;
          if (starve_q == SW'(UNDERRUN_CYCLES - 1)) underrun_q <= 1'b1;
        end
      end
    end
  end

  assign write_audio_out         = (state_q == ISSUE);
  assign left_channel_audio_out  = chan_q;
  assign right_channel_audio_out = chan_q;
  assign sample_ready            = ready_q;
  assign overflow_count          = ovf_q;
  assign underrun                = underrun_q;
  assign fifo_level              = level;

endmodule

// File: tb/tb_audio_out_scheduler.sv
module tb_audio_out_scheduler;

  localparam int SYNC  = 2;
  localparam int DEPTH = 8;
  localparam int UC    = 16;

  logic        CLOCK_50 = 1'b0;
  logic        reset, enable, sample_wr, audio_out_allowed;
  logic [15:0] sample_in;
  logic        sample_ready, write_audio_out, underrun;
  logic [15:0] left_channel_audio_out, right_channel_audio_out;
  logic [7:0]  overflow_count;
  logic [3:0]  fifo_level;

  audio_out_scheduler #(
    .DATA_WIDTH      (16),
    .FIFO_DEPTH      (DEPTH),
    .SYNC_STAGES     (SYNC),
    .READY_MARGIN    (2),
    .UNDERRUN_CYCLES (UC)
  ) dut (
    .CLOCK_50                (CLOCK_50),
    .reset                   (reset),
    .enable                  (enable),
    .sample_in               (sample_in),
    .sample_wr               (sample_wr),
    .sample_ready            (sample_ready),
    .audio_out_allowed       (audio_out_allowed),
    .write_audio_out         (write_audio_out),
    .left_channel_audio_out  (left_channel_audio_out),
    .right_channel_audio_out (right_channel_audio_out),
    .overflow_count          (overflow_count),
    .underrun                (underrun),
    .fifo_level              (fifo_level)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Reference model: FIFO contents and dropped-push count, from the push/drop rules.
  logic [15:0] exp_q[$];
  int          ov_model;
  logic [15:0] last_played;

  // Observed write pulses: {left, right} and the cycle they were seen.
  logic [31:0] obs_q[$];
  int          obs_cyc[$];

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  always @(negedge CLOCK_50) begin
    if (write_audio_out === 1'b1) begin
      obs_q.push_back({left_channel_audio_out, right_channel_audio_out});
      obs_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(negedge CLOCK_50);
  endtask

  task automatic flush_pulse();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    exp_q.delete();
    ov_model = 0;
  endtask

  // One full MCU write; the model records a push or a drop.
  task automatic strobe(input logic [15:0] d);
    sample_in = d;
    sample_wr = 1'b1;
    repeat (SYNC + 3) tick();
    sample_wr = 1'b0;
    repeat (SYNC + 2) tick();
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else if (ov_model < 255) ov_model++;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; sample_wr = 1'b1; audio_out_allowed = 1'b0;
    sample_in = 16'hBEEF;
    repeat (3) tick();
    n_chk++;
    if ({write_audio_out, sample_ready, underrun} !== 3'b000)
      $display("FAIL reset_flags: got wr/ready/underrun=%b expected 000",
               {write_audio_out, sample_ready, underrun});
    else n_pass++;
    n_chk++;
    if ({fifo_level, overflow_count, left_channel_audio_out, right_channel_audio_out} !== '0)
      $display("FAIL reset_values: level=%0d ovf=%0d L=%h R=%h expected all 0",
               fifo_level, overflow_count, left_channel_audio_out, right_channel_audio_out);
    else n_pass++;
    reset = 1'b0;
    repeat (8) tick();
    n_chk++;
    if (fifo_level !== 4'd0)
      $display("FAIL reset_no_push: level=%0d expected 0", fifo_level);
    else n_pass++;
    sample_wr = 1'b0;
    repeat (4) tick();
    n_chk++;
    if (fifo_level !== 4'd0 || sample_ready !== 1'b1)
      $display("FAIL reset_release: level=%0d ready=%b expected 0/1", fifo_level, sample_ready);
    else n_pass++;
  endtask

  task automatic test_single();
    int n;
    bit seen;
    obs_q.delete(); obs_cyc.delete();
    exp_q.delete(); ov_model = 0;
    audio_out_allowed = 1'b1;
    sample_in = 16'h1234;
    sample_wr = 1'b1;
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      tick();
      n++;
      if (write_audio_out === 1'b1) seen = 1;
    end
    n_chk++;
    if (!seen || n > SYNC + 4)
      $display("FAIL single_latency: pulse seen=%0d after %0d clocks, required within %0d",
               seen, n, SYNC + 4);
    else n_pass++;
    repeat (2) tick();
    sample_wr = 1'b0;
    repeat (10) tick();
    n_chk++;
    if (obs_q.size() != 1)
      $display("FAIL single_count: %0d pulses, expected 1", obs_q.size());
    else n_pass++;
    n_chk++;
    if (obs_q.size() < 1 || obs_q[0] !== {16'h1234, 16'h1234})
      $display("FAIL single_data: got %h expected 12341234",
               (obs_q.size() > 0) ? obs_q[0] : 32'hx);
    else n_pass++;
    last_played = 16'h1234;
  endtask

  task automatic test_overflow();
    int lvl;
    audio_out_allowed = 1'b0;
    flush_pulse();
    obs_q.delete(); obs_cyc.delete();
    for (int k = 1; k <= 9; k++) begin
      strobe(16'(k));
      lvl = exp_q.size();
      n_chk++;
      if (fifo_level !== 4'(lvl) || sample_ready !== (lvl < DEPTH - 2) ||
          overflow_count !== 8'(ov_model))
        $display("FAIL overflow_push%0d: level=%0d ready=%b ovf=%0d expected %0d/%b/%0d",
                 k, fifo_level, sample_ready, overflow_count, lvl, (lvl < DEPTH - 2), ov_model);
      else n_pass++;
    end
    audio_out_allowed = 1'b1;
    repeat (40) tick();
    n_chk++;
    if (obs_q.size() != 8)
      $display("FAIL overflow_drain_count: %0d pulses, expected 8", obs_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q[i] !== {e, e})
        $display("FAIL overflow_order%0d: got %h expected %h%h", i, obs_q[i], e, e);
      else n_pass++;
      if (i > 0) begin
        n_chk++;
        if (obs_cyc[i] - obs_cyc[i-1] != 3)
          $display("FAIL overflow_spacing%0d: gap %0d expected 3", i, obs_cyc[i] - obs_cyc[i-1]);
        else n_pass++;
      end
      last_played = e;
    end
  endtask

  task automatic test_underrun();
    int n;
    bit seen;
    audio_out_allowed = 1'b0;
    flush_pulse();
    n_chk++;
    if (underrun !== 1'b0)
      $display("FAIL underrun_cleared: got %b expected 0", underrun);
    else n_pass++;
    audio_out_allowed = 1'b1;
    sample_in = 16'($urandom);
    sample_wr = 1'b1;
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      tick();
      n++;
      if (write_audio_out === 1'b1) seen = 1;
    end
    n_chk++;
    if (!seen) $display("FAIL underrun_pulse: no write pulse within 20 clocks");
    else n_pass++;
    last_played = sample_in;
    // The pulse cycle is the first starved cycle.
    for (int s = 2; s <= 17; s++) begin
      tick();
      if (s == 3) sample_wr = 1'b0;
      if (s == UC - 1) begin
        n_chk++;
        if (underrun !== 1'b0)
          $display("FAIL underrun_early: set at starved cycle %0d, expected 0", s);
        else n_pass++;
      end
    end
    n_chk++;
    if (underrun !== 1'b1)
      $display("FAIL underrun_set: got %b after %0d starved cycles, expected 1", underrun, UC);
    else n_pass++;
    audio_out_allowed = ($urandom_range(0, 1) == 1);
    repeat (20) tick();
    n_chk++;
    if (underrun !== 1'b1)
      $display("FAIL underrun_sticky: got %b expected 1", underrun);
    else n_pass++;
    enable = 1'b0;
    tick();
    n_chk++;
    if (underrun !== 1'b0)
      $display("FAIL underrun_disable: got %b expected 0", underrun);
    else n_pass++;
    enable = 1'b1;
    tick();
  endtask

  task automatic test_flush();
    int t;
    audio_out_allowed = 1'b0;
    flush_pulse();
    obs_q.delete(); obs_cyc.delete();
    for (int k = 0; k < 9; k++) strobe(16'($urandom));
    n_chk++;
    if (fifo_level !== 4'(exp_q.size()) || overflow_count !== 8'(ov_model))
      $display("FAIL flush_fill: level=%0d ovf=%0d expected %0d/%0d",
               fifo_level, overflow_count, exp_q.size(), ov_model);
    else n_pass++;
    audio_out_allowed = 1'b1;
    t = 0;
    while (obs_q.size() < 3 && t < 30) begin
      tick();
      t++;
    end
    audio_out_allowed = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 3; i++) last_played = exp_q.pop_front();
    n_chk++;
    if (fifo_level !== 4'(exp_q.size()) || exp_q.size() != 5)
      $display("FAIL flush_level5: level=%0d expected 5", fifo_level);
    else n_pass++;
    enable = 1'b0;
    tick();
    enable = 1'b1;
    n_chk++;
    if (fifo_level !== 4'd0 || overflow_count !== 8'd0 || underrun !== 1'b0)
      $display("FAIL flush_clear: level=%0d ovf=%0d underrun=%b expected 0/0/0",
               fifo_level, overflow_count, underrun);
    else n_pass++;
    exp_q.delete(); ov_model = 0;
    obs_q.delete(); obs_cyc.delete();
    audio_out_allowed = 1'b1;
    repeat (25) tick();
    n_chk++;
    if (obs_q.size() != 0)
      $display("FAIL flush_no_pulse: %0d pulses after flush, expected 0", obs_q.size());
    else n_pass++;
    n_chk++;
    if (left_channel_audio_out !== last_played || right_channel_audio_out !== last_played)
      $display("FAIL flush_hold: L=%h R=%h expected %h",
               left_channel_audio_out, right_channel_audio_out, last_played);
    else n_pass++;
    // Nothing played since enable rose, so starvation must not count.
    n_chk++;
    if (underrun !== 1'b0)
      $display("FAIL flush_no_underrun: got %b expected 0", underrun);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int off = 0; off <= 4; off++) begin
      int t;
      logic [15:0] s3;
      audio_out_allowed = 1'b0;
      flush_pulse();
      obs_q.delete(); obs_cyc.delete();
      for (int k = 0; k < 3; k++) strobe(16'($urandom));
      s3 = 16'($urandom);
      sample_in = s3;
      sample_wr = 1'b1;
      t = 0;
      repeat (off) begin tick(); t++; end
      audio_out_allowed = 1'b1;
      while (obs_q.size() == 0 && t < 20) begin tick(); t++; end
      audio_out_allowed = 1'b0;
      while (t < SYNC + 4) begin tick(); t++; end
      sample_wr = 1'b0;
      repeat (6) tick();
      exp_q.push_back(s3);
      n_chk++;
      if (fifo_level !== 4'd3)
        $display("FAIL b2b_level_off%0d: level=%0d expected 3", off, fifo_level);
      else n_pass++;
      audio_out_allowed = 1'b1;
      repeat (20) tick();
      audio_out_allowed = 1'b0;
      n_chk++;
      if (obs_q.size() != 4)
        $display("FAIL b2b_count_off%0d: %0d pulses expected 4", off, obs_q.size());
      else n_pass++;
      for (int i = 0; i < obs_q.size() && i < 4; i++) begin
        n_chk++;
        if (obs_q[i] !== {exp_q[i], exp_q[i]})
          $display("FAIL b2b_order_off%0d_%0d: got %h expected %h%h",
                   off, i, obs_q[i], exp_q[i], exp_q[i]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    ov_model = 0;
    last_played = '0;
    test_reset();
    test_single();
    test_overflow();
    test_underrun();
    test_flush();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
